// File: rtl/mure_pkg.sv
// Shared widths, trace entry structs and the slot-pick helper for the
// multiple-retirement trace front end.
package mure_pkg;

    localparam int unsigned ITYPE_LEN = 3;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned CAUSE_LEN = 5;
    localparam int unsigned TVAL_LEN  = 32;
    localparam int unsigned PRIV_LEN  = 2;

    typedef struct packed {
        logic [ITYPE_LEN-1:0] itype;
        logic [XLEN-1:0]      iaddr;
        logic                 iretire;
        logic                 ilastsize;
    } uop_entry_s;

    typedef struct packed {
        logic [CAUSE_LEN-1:0] cause;
        logic [TVAL_LEN-1:0]  tval;
        logic [PRIV_LEN-1:0]  priv;
        logic                 exception;
    } common_entry_s;

    // Index of the lowest set bit; returns 0 for an all-zero mask.
    function automatic logic [4:0] lowest_set_idx(input logic [31:0] mask);
        lowest_set_idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (mask[i]) lowest_set_idx = 5'(i);
        end
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Minimal common_cells-compatible FIFO: registered pointers, head visible
// combinationally on data_o, usage_o wraps to 0 when completely full.
module fifo_v3 #(
    parameter int unsigned DEPTH      = 8,
    parameter type         dtype      = logic [31:0],
    parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    dtype                  mem_q [DEPTH];
    logic [ADDR_DEPTH-1:0] wptr_q, rptr_q;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    logic                  push_ok, pop_ok;

    assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign data_o  = mem_q[rptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok & ~pop_ok) cnt_d = cnt_q + 1'b1;
        if (pop_ok & ~push_ok) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/mure_retire_serializer.sv
// Captures per-cycle retirement bundles into a FIFO and replays them as one
// instruction beat per cycle toward the trace encoder.
module mure_retire_serializer
    import mure_pkg::*;
#(
    parameter int unsigned NrRetiredInstr = 2,
    parameter int unsigned FifoDepth      = 16
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      flush_i,
    input  logic [NrRetiredInstr-1:0]                 iretire_i,
    input  logic [NrRetiredInstr-1:0]                 ilastsize_i,
    input  logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0]  itype_i,
    input  logic [NrRetiredInstr-1:0][XLEN-1:0]       iaddr_i,
    input  logic                                      exception_i,
    input  logic [CAUSE_LEN-1:0]                      cause_i,
    input  logic [TVAL_LEN-1:0]                       tval_i,
    input  logic [PRIV_LEN-1:0]                       priv_i,
    output logic                                      valid_o,
    input  logic                                      ready_i,
    output logic                                      iretire_o,
    output logic                                      ilastsize_o,
    output logic [ITYPE_LEN-1:0]                      itype_o,
    output logic [XLEN-1:0]                           iaddr_o,
    output logic [CAUSE_LEN-1:0]                      cause_o,
    output logic [TVAL_LEN-1:0]                       tval_o,
    output logic [PRIV_LEN-1:0]                       priv_o,
    output logic                                      exception_o,
    output logic                                      last_o,
    output logic [$clog2(FifoDepth)-1:0]              usage_o,
    output logic                                      full_o,
    output logic                                      overflow_o
);

    typedef struct packed {
        uop_entry_s [NrRetiredInstr-1:0] uop;
        common_entry_s                   common;
    } bundle_t;

    typedef enum logic {S_IDLE, S_EMIT} state_e;

    state_e                    state_q, state_d;
    logic [NrRetiredInstr-1:0] mask_q, mask_d;
    logic                      overflow_q;

    bundle_t                   bundle_in, head;
    logic [NrRetiredInstr-1:0] head_iretire, cur_mask;
    logic                      push_cond, push, empty, fire, is_last;
    logic [4:0]                slot_idx;
    uop_entry_s                beat_uop;

    for (genvar gi = 0; gi < NrRetiredInstr; gi++) begin : g_slot
        assign bundle_in.uop[gi].itype     = itype_i[gi];
        assign bundle_in.uop[gi].iaddr     = iaddr_i[gi];
        assign bundle_in.uop[gi].iretire   = iretire_i[gi];
        assign bundle_in.uop[gi].ilastsize = ilastsize_i[gi];
        assign head_iretire[gi]            = head.uop[gi].iretire;
    end
    assign bundle_in.common = '{cause: cause_i, tval: tval_i, priv: priv_i, exception: exception_i};

    // The CPU cannot stall, so a bundle arriving while full is simply lost.
    assign push_cond = (|iretire_i) | exception_i;
    assign push      = push_cond & ~full_o & ~flush_i;

    fifo_v3 #(
        .DEPTH (FifoDepth),
        .dtype (bundle_t)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .full_o  (full_o),
        .empty_o (empty),
        .usage_o (usage_o),
        .data_i  (bundle_in),
        .push_i  (push),
        .data_o  (head),
        .pop_i   (fire & is_last)
    );

    // A freshly presented head uses its own retire bits, so no load bubble.
    assign cur_mask = (state_q == S_EMIT) ? mask_q : head_iretire;
    assign slot_idx = lowest_set_idx(32'(cur_mask));
    assign is_last  = ((cur_mask & (cur_mask - 1'b1)) == '0);
    assign valid_o  = ~empty;
    assign fire     = valid_o & ready_i;

    always_comb begin
        beat_uop = '0;
        for (int i = 0; i < NrRetiredInstr; i++) begin
            if ((|cur_mask) && slot_idx == 5'(i)) beat_uop = head.uop[i];
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        if (flush_i) begin
            state_d = S_IDLE;
            mask_d  = '0;
        end else if (fire) begin
            if (is_last) begin
                state_d = S_IDLE;
                mask_d  = '0;
            end else begin
                state_d = S_EMIT;
                mask_d  = cur_mask & (cur_mask - 1'b1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            if (push_cond && full_o && !flush_i) overflow_q <= 1'b1;
        end
    end

    assign iretire_o   = valid_o & (|cur_mask);
    assign ilastsize_o = valid_o & beat_uop.ilastsize;
    assign itype_o     = valid_o ? beat_uop.itype : '0;
    assign iaddr_o     = valid_o ? beat_uop.iaddr : '0;
    assign cause_o     = valid_o ? head.common.cause : '0;
    assign tval_o      = valid_o ? head.common.tval : '0;
    assign priv_o      = valid_o ? head.common.priv : '0;
    assign last_o      = valid_o & is_last;
    assign exception_o = valid_o & is_last & head.common.exception;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_mure_retire_serializer.sv
// Directed bench for mure_retire_serializer with hand-computed beat values.
module tb_mure_retire_serializer;
    import mure_pkg::*;

    logic                       clk_i = 1'b0;
    logic                       rst_ni, flush_i, exception_i, ready_i;
    logic [1:0]                 iretire_i, ilastsize_i;
    logic [1:0][ITYPE_LEN-1:0]  itype_i;
    logic [1:0][XLEN-1:0]       iaddr_i;
    logic [CAUSE_LEN-1:0]       cause_i, cause_o;
    logic [TVAL_LEN-1:0]        tval_i, tval_o;
    logic [PRIV_LEN-1:0]        priv_i, priv_o;
    logic                       valid_o, iretire_o, ilastsize_o, exception_o, last_o;
    logic [ITYPE_LEN-1:0]       itype_o;
    logic [XLEN-1:0]            iaddr_o;
    logic [3:0]                 usage_o;
    logic                       full_o, overflow_o;

    int n_cmp = 0;
    int n_bad = 0;

    mure_retire_serializer #(.NrRetiredInstr(2), .FifoDepth(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .iretire_i(iretire_i), .ilastsize_i(ilastsize_i), .itype_i(itype_i),
        .iaddr_i(iaddr_i), .exception_i(exception_i), .cause_i(cause_i),
        .tval_i(tval_i), .priv_i(priv_i), .valid_o(valid_o), .ready_i(ready_i),
        .iretire_o(iretire_o), .ilastsize_o(ilastsize_o), .itype_o(itype_o),
        .iaddr_o(iaddr_o), .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o),
        .exception_o(exception_o), .last_o(last_o), .usage_o(usage_o),
        .full_o(full_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_in();
        iretire_i = '0; ilastsize_i = '0; itype_i = '0; iaddr_i = '0;
        exception_i = 1'b0; cause_i = '0; tval_i = '0; priv_i = '0;
    endtask

    task automatic set_pair(input logic [1:0] ret, input logic [31:0] a0, input logic [31:0] a1);
        iretire_i = ret; iaddr_i[0] = a0; iaddr_i[1] = a1;
    endtask

    logic [31:0] exp_q[$];

    initial begin
        clr_in();
        flush_i = 1'b0; ready_i = 1'b1; rst_ni = 1'b0;
        tick(); tick();
        chk("rst_valid", valid_o, 0);
        chk("rst_usage", usage_o, 0);
        chk("rst_full", full_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_iaddr", iaddr_o, 0);
        rst_ni = 1'b1;
        tick();

        // two-slot bundle
        set_pair(2'b11, 32'h100, 32'h104); itype_i[0] = 3'd1; itype_i[1] = 3'd2;
        tick(); clr_in();
        chk("t1_b0_valid", valid_o, 1);
        chk("t1_b0_iaddr", iaddr_o, 32'h100);
        chk("t1_b0_itype", itype_o, 1);
        chk("t1_b0_last", last_o, 0);
        chk("t1_b0_ret", iretire_o, 1);
        tick();
        chk("t1_b1_valid", valid_o, 1);
        chk("t1_b1_iaddr", iaddr_o, 32'h104);
        chk("t1_b1_itype", itype_o, 2);
        chk("t1_b1_last", last_o, 1);
        tick();
        chk("t1_done", valid_o, 0);

        // sparse bundle, then an empty cycle
        set_pair(2'b10, 32'h55, 32'h200); ilastsize_i = 2'b10;
        tick(); clr_in();
        chk("t2_valid", valid_o, 1);
        chk("t2_iaddr", iaddr_o, 32'h200);
        chk("t2_lsize", ilastsize_o, 1);
        chk("t2_last", last_o, 1);
        tick();
        chk("t2_done", valid_o, 0);
        tick();
        chk("t2_nopush", valid_o, 0);

        // exception-only bundle
        exception_i = 1'b1; cause_i = 5'h2; tval_i = 32'hDEAD; priv_i = 2'd3;
        tick(); clr_in();
        chk("t3_valid", valid_o, 1);
        chk("t3_ret", iretire_o, 0);
        chk("t3_exc", exception_o, 1);
        chk("t3_cause", cause_o, 2);
        chk("t3_tval", tval_o, 32'hDEAD);
        chk("t3_priv", priv_o, 3);
        chk("t3_last", last_o, 1);
        chk("t3_iaddr", iaddr_o, 0);
        tick();
        chk("t3_done", valid_o, 0);

        // back-to-back bundles
        set_pair(2'b11, 32'h300, 32'h304);
        tick();
        set_pair(2'b11, 32'h308, 32'h30C);
        chk("t4_b0", iaddr_o, 32'h300);
        chk("t4_b0_last", last_o, 0);
        tick(); clr_in();
        chk("t4_b1", iaddr_o, 32'h304);
        chk("t4_b1_last", last_o, 1);
        chk("t4_b1_exc", exception_o, 0);
        tick();
        chk("t4_b2_valid", valid_o, 1);
        chk("t4_b2", iaddr_o, 32'h308);
        chk("t4_b2_last", last_o, 0);
        tick();
        chk("t4_b3", iaddr_o, 32'h30C);
        chk("t4_b3_last", last_o, 1);
        tick();
        chk("t4_done", valid_o, 0);

        // backpressure, fill and overflow
        ready_i = 1'b0;
        set_pair(2'b11, 32'h400, 32'h404);
        tick(); clr_in();
        for (int k = 0; k < 5; k++) begin
            chk("t5_hold_valid", valid_o, 1);
            chk("t5_hold_iaddr", iaddr_o, 32'h400);
            tick();
        end
        exp_q = '{32'h400, 32'h404};
        for (int k = 0; k < 14; k++) begin
            set_pair(2'b01, 32'h500 + 32'(k), 32'h0);
            exp_q.push_back(32'h500 + 32'(k));
            tick();
        end
        clr_in();
        chk("t5_usage15", usage_o, 15);
        chk("t5_notfull", full_o, 0);
        chk("t5_noovf", overflow_o, 0);
        set_pair(2'b01, 32'h600, 32'h0); exp_q.push_back(32'h600);
        tick();
        chk("t5_full", full_o, 1);
        chk("t5_noovf2", overflow_o, 0);
        set_pair(2'b01, 32'h700, 32'h0);
        tick(); clr_in();
        chk("t5_ovf", overflow_o, 1);
        chk("t5_still_head", iaddr_o, 32'h400);
        ready_i = 1'b1;
        foreach (exp_q[k]) begin
            chk("t5_drain", iaddr_o, 64'(exp_q[k]));
            tick();
        end
        chk("t5_drained", valid_o, 0);
        chk("t5_ovf_sticky", overflow_o, 1);

        // flush mid-bundle
        set_pair(2'b11, 32'h800, 32'h804);
        tick(); clr_in();
        chk("t6_b0", iaddr_o, 32'h800);
        flush_i = 1'b1; set_pair(2'b01, 32'h888, 32'h0);
        tick(); clr_in(); flush_i = 1'b0;
        chk("t6_valid", valid_o, 0);
        chk("t6_usage", usage_o, 0);
        chk("t6_ovf_kept", overflow_o, 1);
        tick();
        chk("t6_discard", valid_o, 0);

        // asynchronous reset mid-bundle
        set_pair(2'b01, 32'h900, 32'h0);
        tick(); clr_in();
        chk("t7_valid", valid_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("t7_rst_valid", valid_o, 0);
        chk("t7_rst_iaddr", iaddr_o, 0);
        chk("t7_rst_usage", usage_o, 0);
        chk("t7_rst_ovf", overflow_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
